// File: rtl/jt10_adpcmb_enc.sv
// rtl/jt10_adpcmb_enc.sv - ADPCM-B (delta-T) encoder and sequential memory writer
// Optional macro JT10_ADPCMB_ENC_FLUSH_EN: stop writes a pending high nibble as {high,4'h0}.
module jt10_adpcmb_enc (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cen,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [15:0] i_astart,
    input  logic [15:0] i_aend,
    input  logic [15:0] i_pcm_in,
    input  logic        i_pcm_valid,
    output logic        o_pcm_ready,
    output logic [23:0] o_addr,
    output logic [7:0]  o_wdata,
    output logic        o_mem_we,
    input  logic        i_mem_ack,
    output logic        o_busy,
    output logic        o_flag,
    input  logic        i_clr_flag
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_Q2   = 3'd2;
    localparam logic [2:0] S_Q1   = 3'd3;
    localparam logic [2:0] S_Q0   = 3'd4;
    localparam logic [2:0] S_UPD  = 3'd5;
    localparam logic [2:0] S_WR   = 3'd6;

    logic [2:0]  r_state;
    logic [23:0] r_addr;
    logic [15:0] r_aend;
    logic [7:0]  r_wdata;
    logic        r_flag;
    logic [15:0] r_pred;
    logic [14:0] r_step;
    logic        r_sign;
    logic [18:0] r_rem;
    logic [2:0]  r_m;
    logic [3:0]  r_hi;
    logic        r_have_hi;
    logic        r_upd_ph;
    logic [15:0] r_dq;
    logic [14:0] r_step_nxt;
    logic        r_stop_pend;
    logic        r_flush;

    logic [16:0] w_diff;
    logic [16:0] w_dn;
    logic [18:0] w_cmp;
    logic        w_ge;
    logic [7:0]  w_t;
    logic [18:0] w_dq_full;
    logic [15:0] w_dq;
    logic [22:0] w_step_prod;
    logic [16:0] w_step_sh;
    logic [14:0] w_step_new;
    logic [17:0] w_sum;
    logic [15:0] w_pred_sat;
    logic [3:0]  w_nib;
    logic        w_at_end;
    logic        w_start_ok;
    logic        w_abort;

    assign w_diff = {i_pcm_in[15], i_pcm_in} - {r_pred[15], r_pred};
    assign w_dn   = w_diff[16] ? (17'd0 - w_diff) : w_diff;

    // Successive approximation runs at 4x scale so step/2 and step/4 stay exact.
    always_comb begin
        w_cmp = {4'b0000, r_step};
        case (r_state)
            S_Q2:    w_cmp = {2'b00, r_step, 2'b00};
            S_Q1:    w_cmp = {3'b000, r_step, 1'b0};
            default: w_cmp = {4'b0000, r_step};
        endcase
    end
    assign w_ge = (r_rem >= w_cmp);

    always_comb begin
        w_t = 8'd57;
        case (r_m)
            3'd4:    w_t = 8'd77;
            3'd5:    w_t = 8'd102;
            3'd6:    w_t = 8'd128;
            3'd7:    w_t = 8'd153;
            default: w_t = 8'd57;
        endcase
    end

    assign w_dq_full   = 19'({r_m, 1'b1}) * 19'(r_step);
    assign w_dq        = 16'(w_dq_full >> 3);
    assign w_step_prod = 23'(r_step) * 23'(w_t);
    assign w_step_sh   = 17'(w_step_prod >> 6);

    always_comb begin
        w_step_new = w_step_sh[14:0];
        if (w_step_sh < 17'd127)
            w_step_new = 15'd127;
        else if (w_step_sh > 17'd24576)
            w_step_new = 15'd24576;
    end

    assign w_sum = r_sign ? ({{2{r_pred[15]}}, r_pred} - {2'b00, r_dq})
                          : ({{2{r_pred[15]}}, r_pred} + {2'b00, r_dq});

    always_comb begin
        w_pred_sat = w_sum[15:0];
        if (w_sum[17:15] != 3'b000 && w_sum[17:15] != 3'b111)
            w_pred_sat = w_sum[17] ? 16'h8000 : 16'h7FFF;
    end

    assign w_nib      = {r_sign, r_m};
    assign w_at_end   = (r_addr == {r_aend, 8'hFF});
    assign w_start_ok = i_start && (i_aend >= i_astart);
    assign w_abort    = i_stop && (r_state != S_IDLE) && (r_state != S_WR);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= 24'd0;
            r_aend      <= 16'd0;
            r_wdata     <= 8'd0;
            r_flag      <= 1'b0;
            r_pred      <= 16'd0;
            r_step      <= 15'd127;
            r_sign      <= 1'b0;
            r_rem       <= 19'd0;
            r_m         <= 3'd0;
            r_hi        <= 4'd0;
            r_have_hi   <= 1'b0;
            r_upd_ph    <= 1'b0;
            r_dq        <= 16'd0;
            r_step_nxt  <= 15'd127;
            r_stop_pend <= 1'b0;
            r_flush     <= 1'b0;
        end else if (i_cen) begin
            if (i_clr_flag)
                r_flag <= 1'b0;
            if (w_start_ok) begin
                r_state     <= S_WAIT;
                r_addr      <= {i_astart, 8'h00};
                r_aend      <= i_aend;
                r_pred      <= 16'd0;
                r_step      <= 15'd127;
                r_have_hi   <= 1'b0;
                r_upd_ph    <= 1'b0;
                r_stop_pend <= 1'b0;
                r_flush     <= 1'b0;
            end else if (w_abort) begin
                r_upd_ph  <= 1'b0;
                r_have_hi <= 1'b0;
`ifdef JT10_ADPCMB_ENC_FLUSH_EN
                if (r_have_hi) begin
                    r_wdata <= {r_hi, 4'h0};
                    r_flush <= 1'b1;
                    r_state <= S_WR;
                end else begin
                    r_state <= S_IDLE;
                end
`else
                r_state <= S_IDLE;
`endif
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (i_pcm_valid) begin
                            r_sign  <= w_diff[16];
                            r_rem   <= {w_dn, 2'b00};
                            r_m     <= 3'd0;
                            r_state <= S_Q2;
                        end
                    end
                    S_Q2, S_Q1, S_Q0: begin
                        r_m <= {r_m[1:0], w_ge};
                        if (w_ge)
                            r_rem <= r_rem - w_cmp;
                        r_state <= (r_state == S_Q2) ? S_Q1 :
                                   (r_state == S_Q1) ? S_Q0 : S_UPD;
                    end
                    S_UPD: begin
                        // Two beats: register the products, then apply and pack.
                        if (!r_upd_ph) begin
                            r_dq       <= w_dq;
                            r_step_nxt <= w_step_new;
                            r_upd_ph   <= 1'b1;
                        end else begin
                            r_upd_ph <= 1'b0;
                            r_pred   <= w_pred_sat;
                            r_step   <= r_step_nxt;
                            if (!r_have_hi) begin
                                r_hi      <= w_nib;
                                r_have_hi <= 1'b1;
                                r_state   <= S_WAIT;
                            end else begin
                                r_wdata   <= {r_hi, w_nib};
                                r_have_hi <= 1'b0;
                                r_state   <= S_WR;
                            end
                        end
                    end
                    S_WR: begin
                        if (i_stop)
                            r_stop_pend <= 1'b1;
                        if (i_mem_ack) begin
                            r_stop_pend <= 1'b0;
                            if (r_flush) begin
                                r_flush <= 1'b0;
                                r_state <= S_IDLE;
                            end else if (w_at_end) begin
                                r_flag  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_addr  <= r_addr + 24'd1;
                                r_state <= (r_stop_pend || i_stop) ? S_IDLE : S_WAIT;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_pcm_ready = (r_state == S_WAIT);
    assign o_mem_we    = (r_state == S_WR);
    assign o_busy      = (r_state != S_IDLE);
    assign o_addr      = r_addr;
    assign o_wdata     = r_wdata;
    assign o_flag      = r_flag;

endmodule
